inst_fetch: RTL and testbench

Instruction-fetch stage of the core. It holds the PC, issues word requests to instruction memory, and buffers in-order responses in a small FIFO. It presents {inst, pc} to decode through a valid/ready handshake; decode feeds inst to the immediate extractor and control decode. It also accepts redirects from branch/jump resolution and discards stale in-flight fetches.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/inst_fetch_if.sv | 28 ++
 rtl/inst_fetch_fifo.sv | 65 ++++++
 rtl/inst_fetch.sv | 81 ++++++++
 tb/tb_inst_fetch.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Core-wide constants and types shared by fetch, decode and the immediate extractor.
package riscv_pkg;
    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0]   RESET_PC_DEF = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP          = 32'h0000_0013;

    typedef enum logic [6:0] {
        op_R        = 7'b0110011,
        op_I_load   = 7'b0000011,
        op_I_jalr   = 7'b1100111,
        op_I_cal    = 7'b0010011,
        op_S        = 7'b0100011,
        op_B        = 7'b1100011,
        op_U_lui    = 7'b0110111,
        op_U_auipc  = 7'b0010111,
        op_J        = 7'b1101111
    } opcode_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: imem request/response, redirect input and decode handshake.
interface inst_fetch_if;
    import riscv_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              id_valid;
    logic              id_ready;
    logic [INST_W-1:0] id_inst;
    logic [XLEN-1:0]   id_pc;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/inst_fetch_fifo.sv
// Registered instruction buffer of {pc, inst} entries with flush; head reads as zero when empty.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, credit-limited imem requests, in-order response buffering, redirect with stale-response drop.
module inst_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.master fif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
    logic [CW-1:0]   out_q, out_d, drop_q, drop_d, fifo_count;
    logic [CW+1:0]   used;
    logic            accept, rsp_keep, rsp_drop, push, pop, fifo_empty, fifo_full;
    fetch_entry_t    head;

    // Credits count everything that may still land in the buffer, including responses we will discard.
    assign used     = (CW+2)'(out_q) + (CW+2)'(fifo_count) + (CW+2)'(drop_q);
    assign redir_pc = {fif.redirect_pc[XLEN-1:2], 2'b00};

    assign fif.imem_req_valid = rst_n && !fif.redirect_valid && (used < (CW+2)'(FIFO_DEPTH));
    assign fif.imem_req_addr  = pc_q;
    assign fif.id_valid       = !fifo_empty;
    assign fif.id_inst        = head.inst;
    assign fif.id_pc          = head.pc;

    assign accept   = fif.imem_req_valid && fif.imem_req_ready;
    assign rsp_keep = fif.imem_rsp_valid && (drop_q == '0);
    assign rsp_drop = fif.imem_rsp_valid && (drop_q != '0);
    assign pop      = fif.id_valid && fif.id_ready;
    assign push     = rsp_keep && !fif.redirect_valid && (!fifo_full || pop);

    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        out_d    = out_q;
        drop_d   = drop_q;
        if (fif.redirect_valid) begin
            // A response landing now belongs to the flushed stream and consumes one drop.
            pc_d     = redir_pc;
            rsp_pc_d = redir_pc;
            out_d    = '0;
            drop_d   = drop_q + out_q - CW'(fif.imem_rsp_valid);
        end else begin
            if (accept)   pc_d     = pc_q + 32'd4;
            if (rsp_keep) rsp_pc_d = rsp_pc_q + 32'd4;
            out_d  = out_q + CW'(accept) - CW'(rsp_keep);
            drop_d = drop_q - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fif.redirect_valid),
        .push      (push),
        .push_data ('{pc: rsp_pc_q, inst: fif.imem_rsp_data}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );
endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: in-order memory model, stream-level fetch model, credit bookkeeping.
module tb_inst_fetch;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_if ifc ();

    inst_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (ifc.master)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } mreq_t;

    mreq_t       mq[$];
    int          n_chk = 0, n_fail = 0, cyc = 0, epoch = 0, buffered = 0, n_pops = 0;
    int          p_rdy, p_idr, p_rsp, p_redir, lat_extra;
    logic        force_redir = 1'b0;
    logic [31:0] force_tgt = '0;
    logic [31:0] exp_req, exp_id, hold_pc, hold_inst;
    logic        stall_prev = 1'b0;

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        ifc.imem_req_ready = 1'b0;
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rsp_data  = '0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = '0;
        ifc.id_ready       = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        buffered   = 0;
        epoch++;
        exp_req    = RPC;
        exp_id     = RPC;
        stall_prev = 1'b0;
    endtask

    task automatic cycle();
        logic        redir, rsp_v, acc, pop, push;
        logic [31:0] tgt, tmp;
        @(negedge clk);
        tmp   = $urandom();
        tgt   = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | (tmp & 32'hF)) : (tmp & 32'h0000_0FFF);
        if (force_redir) tgt = force_tgt;
        redir = force_redir || ($urandom_range(999) < p_redir);
        rsp_v = (mq.size() > 0) && ($urandom_range(99) < p_rsp);
        if (rsp_v) rsp_v = (mq[0].due <= cyc);
        ifc.imem_req_ready = ($urandom_range(99) < p_rdy);
        ifc.id_ready       = ($urandom_range(99) < p_idr);
        ifc.redirect_valid = redir;
        ifc.redirect_pc    = tgt;
        ifc.imem_rsp_valid = rsp_v;
        ifc.imem_rsp_data  = rsp_v ? inst_of(mq[0].addr) : $urandom();
        #1;
        acc = ifc.imem_req_valid && ifc.imem_req_ready;
        pop = ifc.id_valid && ifc.id_ready;
        chk("req_valid", ifc.imem_req_valid, !redir && (mq.size() + buffered < DEPTH));
        chk("id_valid", ifc.id_valid, buffered > 0);
        chk("credit_bound", (mq.size() + buffered) <= DEPTH, 1);
        if (stall_prev) begin
            chk("hold_pc", ifc.id_pc, hold_pc);
            chk("hold_inst", ifc.id_inst, hold_inst);
        end
        if (acc) begin
            chk("req_addr", ifc.imem_req_addr, exp_req);
            exp_req = exp_req + 32'd4;
        end
        if (pop && !redir) begin
            chk("id_pc", ifc.id_pc, exp_id);
            chk("id_inst", ifc.id_inst, inst_of(exp_id));
            exp_id = exp_id + 32'd4;
            n_pops++;
        end
        push = rsp_v && (mq[0].ep == epoch) && !redir;
        if (rsp_v) void'(mq.pop_front());
        if (acc) mq.push_back('{ifc.imem_req_addr, cyc + 1 + int'($urandom_range(lat_extra)), epoch});
        if (redir) begin
            buffered = 0;
            epoch++;
            exp_req  = tgt & 32'hFFFF_FFFC;
            exp_id   = tgt & 32'hFFFF_FFFC;
        end else begin
            buffered = buffered + int'(push) - int'(pop);
        end
        chk("no_overflow", buffered <= DEPTH, 1);
        stall_prev = ifc.id_valid && !ifc.id_ready && !redir;
        hold_pc    = ifc.id_pc;
        hold_inst  = ifc.id_inst;
        cyc++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_req_valid"}, ifc.imem_req_valid, 0);
        chk({tag, "_req_addr"}, ifc.imem_req_addr, RPC);
        chk({tag, "_id_valid"}, ifc.id_valid, 0);
        chk({tag, "_id_inst"}, ifc.id_inst, 0);
        chk({tag, "_id_pc"}, ifc.id_pc, 0);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        p_rdy = 100; p_idr = 100; p_rsp = 100; p_redir = 0; lat_extra = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // streaming with ready memory and decode
        run(20);
        // decode stall fills the buffer, then resume
        p_idr = 0;  run(10);
        p_idr = 100; run(10);
        // redirects with responses in flight, including an unaligned target
        force_redir = 1'b1; force_tgt = 32'h0000_0200; run(1);
        force_redir = 1'b0; run(8);
        force_redir = 1'b1; force_tgt = 32'h0000_0203; run(1);
        force_redir = 1'b0; run(8);
        // memory not accepting
        p_rdy = 0;   run(5);
        p_rdy = 100; run(8);
        // asynchronous reset with a full buffer
        p_idr = 0; run(6);
        #2 rst_n = 1'b0;
        idle_inputs();
        #1 check_reset_outputs("midreset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p_idr = 100; run(10);

        // random mix
        p_rdy = 70; p_idr = 70; p_rsp = 70; p_redir = 30; lat_extra = 3;
        run(3000);
        chk("progress", n_pops > 200, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
